// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe
//   Two-stage pipelined barrel shifter/rotator for the ALU. Stage 1 registers
//   the selected operand, shift amount and opcode. Stage 2 registers the
//   computed result with its carry, zero and illegal-op flags. Valid/ready on
//   both sides, so the block stalls cleanly under downstream backpressure.
//
// Ports
//   CLK, rst            clock (rising edge), asynchronous active-low reset
//   clr                 synchronous flush of both stages
//   A, B, sel_b         operands and operand select (0 = A, 1 = B)
//   shamt               unsigned shift amount (over-range values allowed)
//   ALU_FUN             000 SRL, 001 SLL, 010 SRA, 011 ROR, 100 ROL, others reserved
//   in_valid, in_ready  request handshake
//   SHIFT_OUT           result
//   carry_out           last bit shifted or rotated out
//   zero_flag, err_flag result is zero / reserved opcode was used
//   out_valid, out_ready result handshake

module shift_unit_pipe #(
    parameter int DATA_WIDTH  = 16,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   clr,
    input  logic [DATA_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]  B,
    input  logic                   sel_b,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic [2:0]             ALU_FUN,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  SHIFT_OUT,
    output logic                   carry_out,
    output logic                   zero_flag,
    output logic                   err_flag,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int LOG_W = $clog2(DATA_WIDTH);
    localparam logic [LOG_W:0] W_L = (LOG_W + 1)'(DATA_WIDTH);

    logic                   r_s1_valid;
    logic [DATA_WIDTH-1:0]  r_s1_op;
    logic [SHAMT_WIDTH-1:0] r_s1_shamt;
    logic [2:0]             r_s1_fun;

    logic                   r_s2_valid;
    logic [DATA_WIDTH-1:0]  r_s2_res;
    logic                   r_s2_carry;
    logic                   r_s2_zero;
    logic                   r_s2_err;

    logic                   w_s2_load;
    logic                   w_s1_load;

    logic [DATA_WIDTH:0]    w_srl_ext;
    logic [DATA_WIDTH:0]    w_sra_ext;
    logic [DATA_WIDTH:0]    w_sll_ext;
    logic [LOG_W-1:0]       w_rot;
    logic [LOG_W:0]         w_rot_inv;
    logic [DATA_WIDTH-1:0]  w_ror;
    logic [DATA_WIDTH-1:0]  w_rol;
    logic                   w_nz;

    logic [DATA_WIDTH-1:0]  w_res;
    logic                   w_carry;
    logic                   w_err;
    logic                   w_zero;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = !clr && w_s1_load;

    // Shifts run on operands widened by one bit so the bit that falls off the
    // end lands in the extra position: that bit is the carry. This yields
    // operand[n-1] / operand[W-n] for 1 <= n <= W, 0 (or sign for SRA) beyond,
    // and 0 for n == 0 without any index arithmetic.
    assign w_srl_ext = {r_s1_op, 1'b0} >> r_s1_shamt;
    assign w_sra_ext = $signed({r_s1_op, 1'b0}) >>> r_s1_shamt;
    assign w_sll_ext = {1'b0, r_s1_op} << r_s1_shamt;

    // Rotates use n mod W; a shift by W (when the residue is 0) yields zero,
    // so the OR of both halves degenerates to the operand itself.
    assign w_rot     = r_s1_shamt[LOG_W-1:0];
    assign w_rot_inv = W_L - {1'b0, w_rot};
    assign w_ror     = (r_s1_op >> w_rot) | (r_s1_op << w_rot_inv);
    assign w_rol     = (r_s1_op << w_rot) | (r_s1_op >> w_rot_inv);
    assign w_nz      = |r_s1_shamt;

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_err   = 1'b0;
        case (r_s1_fun)
            3'b000: begin
                w_res   = w_srl_ext[DATA_WIDTH:1];
                w_carry = w_srl_ext[0];
            end
            3'b001: begin
                w_res   = w_sll_ext[DATA_WIDTH-1:0];
                w_carry = w_sll_ext[DATA_WIDTH];
            end
            3'b010: begin
                w_res   = w_sra_ext[DATA_WIDTH:1];
                w_carry = w_sra_ext[0];
            end
            3'b011: begin
                w_res   = w_ror;
                w_carry = w_nz & w_ror[DATA_WIDTH-1];
            end
            3'b100: begin
                w_res   = w_rol;
                w_carry = w_nz & w_rol[0];
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    assign w_zero = (w_res == '0);

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_shamt <= '0;
            r_s1_fun   <= '0;
        end else if (clr) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op    <= sel_b ? B : A;
                r_s1_shamt <= shamt;
                r_s1_fun   <= ALU_FUN;
            end
        end
    end

    // Result data only updates when a real operation moves in, so the output
    // and flags keep their last values while out_valid is low.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_s2_valid <= 1'b0;
            r_s2_res   <= '0;
            r_s2_carry <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_err   <= 1'b0;
        end else if (clr) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_res   <= w_res;
                r_s2_carry <= w_carry;
                r_s2_zero  <= w_zero;
                r_s2_err   <= w_err;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign SHIFT_OUT = r_s2_res;
    assign carry_out = r_s2_carry;
    assign zero_flag = r_s2_zero;
    assign err_flag  = r_s2_err;

endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
Parametrised, pipelined barrel shifter that succeeds the single-bit shift unit.
- Shifts or rotates a selected operand (A or B) by a variable amount.
- Five operations: logical left/right, arithmetic right, rotate left/right.
- Produces zero, carry-out and illegal-op flags.
- Sits beside the arithmetic/logic units inside the ALU. Valid/ready handshakes on both sides, so it can stall under downstream backpressure.

Parameters:
DATA_WIDTH, 16, operand/result width; must be a power of two, 4 or more.
SHAMT_WIDTH, 5, shift-amount width; must be at least log2(DATA_WIDTH)+1, so over-range amounts are representable.

Ports:
CLK  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
clr  input  1  synchronous flush; drops all in-flight operations.
A  input  DATA_WIDTH  operand A.
B  input  DATA_WIDTH  operand B.
sel_b  input  1  0 selects A, 1 selects B.
shamt  input  SHAMT_WIDTH  unsigned shift amount.
ALU_FUN  input  3  operation code.
in_valid  input  1  request valid.
in_ready  output  1  block can accept the request this cycle.
SHIFT_OUT  output  DATA_WIDTH  result.
carry_out  output  1  last bit shifted or rotated out.
zero_flag  output  1  SHIFT_OUT == 0.
err_flag  output  1  reserved ALU_FUN was used.
out_valid  output  1  result valid (replaces the level SHIFT_Flag).
out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (rst low, asynchronous): both stage valids 0; SHIFT_OUT 0, carry_out 0, zero_flag 0, err_flag 0, out_valid 0.
- Reset mid-operation discards all in-flight data. After release, nothing is emitted until a new request is accepted.
- Transfer occurs on a rising edge when valid && ready on that interface.
- Pipeline has two stages, each a valid bit plus data registers:
  - S1 captures the selected operand, shamt and ALU_FUN.
  - S2 holds the computed result and flags; its outputs drive the out_* ports.
- Latency: an accepted request appears on out_valid exactly 2 cycles later when there is no stall.
- Throughput: 1 operation per cycle.
- Stage advance: S2 loads when !S2.valid || out_ready. S1 loads when !S1.valid || S2 loads. in_ready = !S1.valid || S2 loads; a combinational path from out_ready is permitted.
- Stall: while out_valid && !out_ready, SHIFT_OUT and the flags hold stable and nothing is lost. S1 holds once S2 is blocked, and in_ready drops once S1 is full.
- Order: results are strictly in request order; no drops or duplicates.
- clr: on the next edge both stage valids go to 0 and out_valid goes to 0. A request presented with in_valid in the same cycle as clr is not accepted; in_ready = 0 while clr = 1.
- ALU_FUN codes:
  - 000 SRL
  - 001 SLL
  - 010 SRA (sign fill)
  - 011 ROR
  - 100 ROL
  - 101..111 reserved: result 0, carry 0, err_flag 1, zero_flag 1.
- Amount rules, with n = shamt and W = DATA_WIDTH:
  - n == 0: result equals the operand, carry 0.
  - SRL/SLL with n >= W: result 0.
  - SRA with n >= W: all bits equal the operand sign.
  - ROR/ROL use n mod W.
- Carry rules (n != 0):
  - SRL/SRA, n <= W: operand[n-1].
  - SRL, n > W: 0. SRA, n > W: operand sign.
  - SLL, n <= W: operand[W-n]. SLL, n > W: 0.
  - ROR: result[W-1]. ROL: result[0]. This applies even when n mod W == 0.
- Flag timing: zero_flag and err_flag are registered alongside the result. Flags are meaningful only while out_valid = 1 and hold their last values otherwise.
- No latches; every combinational path is fully assigned for all ALU_FUN values.

Test Plan:
1. Reset, then A=16'h8001, sel_b=0, SRL, n=1, out_ready=1 -> 2 cycles later out_valid=1, SHIFT_OUT=16'h4000, carry_out=1, zero_flag=0, err_flag=0.
2. B=16'hF0F0, sel_b=1, SRA, n=4 -> SHIFT_OUT=16'hFF0F, carry_out=0. Same operand with SRA, n=20 -> 16'hFFFF, carry_out=1.
3. A=16'h1234, ROL, n=4 -> 16'h2341, carry_out=1. ROR, n=16 -> 16'h1234, carry_out=0. SLL of 16'hFFFF, n=17 -> 16'h0000, carry_out=0, zero_flag=1.
4. ALU_FUN=3'b111, A=16'hABCD -> SHIFT_OUT=0, err_flag=1, zero_flag=1, carry_out=0.
5. Stream 6 back-to-back SLL n=1 ops on A=1..6. Hold out_ready=0 for cycles 3-6 -> in_ready falls once S1 is full, output holds stable, and results 2,4,6,8,10,12 arrive in order with none lost.
6. Two ops in flight, then pulse clr, and separately pulse rst low mid-stream -> out_valid=0 on the next edge (immediately for rst), with no stale result emitted afterwards.
